// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction arbiter: widths, requester count,
// timing defaults and the arbiter state encoding.
package i2c_pkg;

  localparam int ADDR_W             = 7;
  localparam int DATA_W             = 16;
  localparam int N_REQ              = 3;
  localparam int GIDX_W             = 2;
  localparam int IDLE_CYCLES_DEF    = 16;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LAUNCH     = 3'd1,
    WAIT_START = 3'd2,
    BUSY       = 3'd3,
    FINISH     = 3'd4
  } state_t;

  function automatic logic [GIDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [GIDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = GIDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: returns a one-hot grant for the first
// requester found searching upward from the one after the last grant.
module rr_picker
  import i2c_pkg::*;
(
  input  logic [N_REQ-1:0]  i_req,
  input  logic [GIDX_W-1:0] i_last_grant,
  output logic [N_REQ-1:0]  o_grant
);

  logic [GIDX_W-1:0] w_idx;

  // Walk the candidates farthest-first so the nearest active one overwrites.
  always_comb begin
    o_grant = '0;
    w_idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = GIDX_W'((int'(i_last_grant) + k) % N_REQ);
      if (i_req[w_idx]) o_grant = N_REQ'(1) << w_idx;
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Arbitrates three requesters onto one I2C generator CPU interface, tracking
// each transaction from start strobe to bus idle (or start timeout).
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int IDLE_CYCLES    = IDLE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [N_REQ-1:0]          REQ,
  input  logic [N_REQ-1:0]          REQ_RNW,
  input  logic [N_REQ*ADDR_W-1:0]   REQ_ADDR,
  input  logic [N_REQ*DATA_W-1:0]   REQ_WDATA,
  output logic [N_REQ-1:0]          GNT,
  output logic [N_REQ-1:0]          DONE,
  output logic                      ERR,
  output logic [DATA_W-1:0]         RD_DATA_OUT,
  output logic                      START_STB,
  output logic                      RNW,
  output logic [ADDR_W-1:0]         I2C_ADDR,
  output logic [DATA_W-1:0]         WR_DATA,
  input  logic                      SCL,
  input  logic [DATA_W-1:0]         RD_DATA
);

  localparam int CNT_TOP = (IDLE_CYCLES > TIMEOUT_CYCLES) ? IDLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_REQ-1:0]    r_gnt;
  logic [GIDX_W-1:0]   r_last_grant;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;
  logic                r_rnw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rd_data;

  logic [N_REQ-1:0]    w_pick;
  logic [GIDX_W-1:0]   w_pick_idx;
  logic                w_load;
  logic                w_cnt_clr;
  logic                w_cnt_inc;
  logic                w_set_err;
  logic                w_finish;

  rr_picker u_rr_picker (
    .i_req        (REQ),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick)
  );

  assign w_pick_idx = onehot_to_idx(w_pick);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_set_err   = 1'b0;
    w_finish    = 1'b0;
    START_STB   = 1'b0;
    DONE        = '0;
    ERR         = 1'b0;
    case (r_state)
      IDLE: begin
        if (|REQ) begin
          w_load      = 1'b1;
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        START_STB   = 1'b1;
        w_cnt_clr   = 1'b1;
        w_state_nxt = WAIT_START;
      end
      WAIT_START: begin
        if (!SCL) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = BUSY;
        end else if (r_cnt >= TO_LAST) begin
          w_cnt_clr   = 1'b1;
          w_set_err   = 1'b1;
          w_state_nxt = FINISH;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      BUSY: begin
        // The current cycle is the IDLE_CYCLES-th consecutive high one when
        // the counter already holds IDLE_CYCLES-1.
        if (!SCL) begin
          w_cnt_clr   = 1'b1;
        end else if (r_cnt >= IDLE_LAST) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = FINISH;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      FINISH: begin
        DONE        = r_gnt;
        ERR         = r_err;
        w_finish    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // One counter serves both the start timeout and the bus-idle detector,
  // since the two phases never overlap.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_gnt        <= '0;
      r_last_grant <= GIDX_W'(N_REQ - 1);
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_rnw        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rd_data    <= '0;
    end else begin
      if (w_load) begin
        r_gnt   <= w_pick;
        r_rnw   <= REQ_RNW[w_pick_idx];
        r_addr  <= REQ_ADDR[w_pick_idx*ADDR_W +: ADDR_W];
        r_wdata <= REQ_WDATA[w_pick_idx*DATA_W +: DATA_W];
      end

      if (w_cnt_clr)                          r_cnt <= '0;
      else if (w_cnt_inc && r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);

      if (w_set_err)     r_err <= 1'b1;
      else if (w_finish) r_err <= 1'b0;

      if (w_finish) begin
        r_gnt        <= '0;
        r_last_grant <= onehot_to_idx(r_gnt);
        if (r_rnw && !r_err) r_rd_data <= RD_DATA;
      end
    end
  end

  assign GNT         = r_gnt;
  assign RNW         = r_rnw;
  assign I2C_ADDR    = r_addr;
  assign WR_DATA     = r_wdata;
  assign RD_DATA_OUT = r_rd_data;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Randomized bench for i2c_arbiter: a behavioural generator/receptor drives SCL,
// a transaction-level model fills a scoreboard that a monitor drains on DONE.
module tb_i2c_arbiter;

  localparam int TO_CYC   = 64;
  localparam int IDLE_CYC = 16;

  logic        Clk;
  logic        Reset;
  logic [2:0]  REQ;
  logic [2:0]  REQ_RNW;
  logic [20:0] REQ_ADDR;
  logic [47:0] REQ_WDATA;
  logic [2:0]  GNT;
  logic [2:0]  DONE;
  logic        ERR;
  logic [15:0] RD_DATA_OUT;
  logic        START_STB;
  logic        RNW;
  logic [6:0]  I2C_ADDR;
  logic [15:0] WR_DATA;
  logic        SCL;
  logic [15:0] RD_DATA;

  i2c_arbiter #(.IDLE_CYCLES(IDLE_CYC), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .Clk(Clk), .Reset(Reset), .REQ(REQ), .REQ_RNW(REQ_RNW), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .GNT(GNT), .DONE(DONE), .ERR(ERR), .RD_DATA_OUT(RD_DATA_OUT),
    .START_STB(START_STB), .RNW(RNW), .I2C_ADDR(I2C_ADDR), .WR_DATA(WR_DATA),
    .SCL(SCL), .RD_DATA(RD_DATA)
  );

  typedef struct {
    int          idx;
    logic        rnw;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic        err;
    logic [15:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rx_mem  [128];
  logic [15:0] exp_mem [128];
  int          model_last;
  logic [15:0] model_rd;
  logic        txn_rnw   [3][4];
  logic [6:0]  txn_addr  [3][4];
  logic [15:0] txn_wdata [3][4];
  bit          scl_stuck;
  bit          gen_busy;
  int          n_cmp;
  int          n_err;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_fields(input int i, input logic rnw, input logic [6:0] a, input logic [15:0] d);
    REQ_RNW[i]           = rnw;
    REQ_ADDR[7*i +: 7]   = a;
    REQ_WDATA[16*i +: 16] = d;
  endtask

  // Transaction-level model: every requester with quota left keeps REQ high,
  // so service order is a plain rotation over those with work remaining.
  task automatic model_round(input int q0, input int q1, input int q2, input bit stuck);
    int   q[3];
    int   k[3];
    int   g;
    int   c;
    exp_t e;
    q[0] = q0; q[1] = q1; q[2] = q2;
    k[0] = 0;  k[1] = 0;  k[2] = 0;
    while (q[0] + q[1] + q[2] > 0) begin
      g = -1;
      for (int s = 1; s <= 3; s++) begin
        c = (model_last + s) % 3;
        if (g < 0 && q[c] > 0) g = c;
      end
      e.idx   = g;
      e.rnw   = txn_rnw[g][k[g]];
      e.addr  = txn_addr[g][k[g]];
      e.wdata = txn_wdata[g][k[g]];
      e.err   = stuck;
      if (!stuck) begin
        if (e.rnw) model_rd = exp_mem[e.addr];
        else       exp_mem[e.addr] = e.wdata;
      end
      e.rd = model_rd;
      exp_q.push_back(e);
      model_last = g;
      q[g]--;
      k[g]++;
    end
  endtask

  task automatic run_round(input int q0, input int q1, input int q2, input bit stuck, input bit drop_early);
    int q[3];
    int k[3];
    int budget;
    model_round(q0, q1, q2, stuck);
    scl_stuck = stuck;
    q[0] = q0; q[1] = q1; q[2] = q2;
    k[0] = 0;  k[1] = 0;  k[2] = 0;
    budget = 300 * (q0 + q1 + q2) + 50;
    for (int i = 0; i < 3; i++) begin
      if (q[i] > 0) begin
        set_fields(i, txn_rnw[i][0], txn_addr[i][0], txn_wdata[i][0]);
        REQ[i] = 1'b1;
      end
    end
    while ((q[0] + q[1] + q[2]) > 0 && budget > 0) begin
      @(negedge Clk);
      budget--;
      for (int i = 0; i < 3; i++) begin
        if (DONE[i] && q[i] > 0) begin
          q[i]--;
          k[i]++;
          if (q[i] > 0) set_fields(i, txn_rnw[i][k[i]], txn_addr[i][k[i]], txn_wdata[i][k[i]]);
          else          REQ[i] = 1'b0;
        end else if (GNT[i]) begin
          if (drop_early && q[i] == 1) REQ[i] = 1'b0;
          if ($urandom_range(0, 3) == 0) set_fields(i, 1'($urandom), 7'($urandom), 16'($urandom));
        end
      end
    end
    check("round_completed", 32'(budget > 0), 32'd1);
    REQ = 3'b000;
    repeat (3) @(negedge Clk);
    scl_stuck = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Generator + receptor: answers each START_STB with a burst of SCL activity
  // (high phases shorter than the idle window), then stores or returns data.
  initial begin
    logic [6:0]  a;
    logic        r;
    logic [15:0] w;
    int          nb;
    SCL      = 1'b1;
    RD_DATA  = '0;
    gen_busy = 1'b0;
    forever begin
      @(negedge Clk);
      if (START_STB && !scl_stuck) begin
        gen_busy = 1'b1;
        a = I2C_ADDR;
        r = RNW;
        w = WR_DATA;
        repeat ($urandom_range(1, 20)) @(negedge Clk);
        nb = $urandom_range(4, 10);
        for (int b = 0; b < nb; b++) begin
          SCL = 1'b0;
          repeat ($urandom_range(1, 4)) @(negedge Clk);
          SCL = 1'b1;
          repeat ($urandom_range(1, 5)) @(negedge Clk);
        end
        if (r) RD_DATA = rx_mem[a];
        else   rx_mem[a] = w;
        gen_busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever DONE is presented.
  initial begin
    int          cyc;
    int          stb_cyc;
    int          stb_cnt;
    logic [2:0]  prev_gnt;
    logic        snap_rnw;
    logic [6:0]  snap_addr;
    logic [15:0] snap_wdata;
    bit          rd_pend;
    logic [15:0] rd_exp;
    exp_t        e;
    cyc = 0; stb_cyc = 0; stb_cnt = 0; prev_gnt = '0; rd_pend = 1'b0; rd_exp = '0;
    snap_rnw = 1'b0; snap_addr = '0; snap_wdata = '0;
    forever begin
      @(negedge Clk);
      cyc++;
      if (!Reset) begin
        rd_pend  = 1'b0;
        stb_cnt  = 0;
        prev_gnt = GNT;
      end else begin
        if (rd_pend) begin
          check("rd_data_out", 32'(RD_DATA_OUT), 32'(rd_exp));
          rd_pend = 1'b0;
        end
        if (START_STB) begin
          stb_cnt++;
          stb_cyc    = cyc;
          snap_rnw   = RNW;
          snap_addr  = I2C_ADDR;
          snap_wdata = WR_DATA;
        end
        if (GNT != 3'b000 && prev_gnt == 3'b000) begin
          if (exp_q.size() == 0) check("grant_unexpected", 32'(GNT), 32'd0);
          else                   check("grant", 32'(GNT), 32'd1 << exp_q[0].idx);
        end
        if (DONE != 3'b000) begin
          if (exp_q.size() == 0) begin
            check("done_unexpected", 32'(DONE), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("done",            32'(DONE),       32'd1 << e.idx);
            check("err",             32'(ERR),        32'(e.err));
            check("gnt_in_finish",   32'(GNT),        32'd1 << e.idx);
            check("i2c_addr",        32'(snap_addr),  32'(e.addr));
            check("wr_data",         32'(snap_wdata), 32'(e.wdata));
            check("rnw",             32'(snap_rnw),   32'(e.rnw));
            check("addr_held",       32'(I2C_ADDR),   32'(e.addr));
            check("wdata_held",      32'(WR_DATA),    32'(e.wdata));
            check("rnw_held",        32'(RNW),        32'(e.rnw));
            check("start_stb_count", 32'(stb_cnt),    32'd1);
            if (e.err) check("timeout_latency", 32'((cyc - stb_cyc) >= TO_CYC), 32'd1);
            if (!e.err && !e.rnw) check("receptor_store", 32'(rx_mem[e.addr]), 32'(e.wdata));
            stb_cnt = 0;
            rd_pend = 1'b1;
            rd_exp  = e.rd;
          end
        end else if (ERR) begin
          check("err_without_done", 32'(ERR), 32'd0);
        end
        prev_gnt = GNT;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"},         32'(GNT),         32'd0);
    check({tag, "_done"},        32'(DONE),        32'd0);
    check({tag, "_err"},         32'(ERR),         32'd0);
    check({tag, "_start_stb"},   32'(START_STB),   32'd0);
    check({tag, "_rnw"},         32'(RNW),         32'd0);
    check({tag, "_i2c_addr"},    32'(I2C_ADDR),    32'd0);
    check({tag, "_wr_data"},     32'(WR_DATA),     32'd0);
    check({tag, "_rd_data_out"}, 32'(RD_DATA_OUT), 32'd0);
  endtask

  initial begin
    logic [15:0] v;
    exp_t        e;
    int          q0, q1, q2;
    n_cmp = 0; n_err = 0;
    scl_stuck = 1'b0;
    REQ = '0; REQ_RNW = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    model_last = 2;
    model_rd   = '0;
    for (int a = 0; a < 128; a++) begin
      v = 16'($urandom);
      rx_mem[a]  = v;
      exp_mem[a] = v;
    end
    Reset = 1'b1;
    #3 Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check_outputs_zero("reset");
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    // Single write from requester 0.
    txn_rnw[0][0] = 1'b0; txn_addr[0][0] = 7'h2A; txn_wdata[0][0] = 16'hBEEF;
    run_round(1, 0, 0, 1'b0, 1'b0);

    // Read by requester 1, which drops REQ while its transaction is in flight.
    rx_mem[7'h50] = 16'h1234; exp_mem[7'h50] = 16'h1234;
    txn_rnw[1][0] = 1'b1; txn_addr[1][0] = 7'h50; txn_wdata[1][0] = 16'h5A5A;
    run_round(0, 1, 0, 1'b0, 1'b1);

    // Start timeout: SCL never falls; read result must not be loaded.
    txn_rnw[2][0] = 1'b1; txn_addr[2][0] = 7'h33; txn_wdata[2][0] = 16'h0000;
    run_round(0, 0, 1, 1'b1, 1'b0);

    // All three requesting; requester 0 has two transactions -> 0,1,2,0.
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 2; j++) begin
        txn_rnw[i][j]   = 1'($urandom);
        txn_addr[i][j]  = 7'($urandom_range(0, 7));
        txn_wdata[i][j] = 16'($urandom);
      end
    run_round(2, 1, 1, 1'b0, 1'b0);

    // Reset while the bus is active: transaction abandoned, no DONE.
    set_fields(1, 1'b1, 7'h11, 16'h0000);
    e.idx = 1; e.rnw = 1'b1; e.addr = 7'h11; e.wdata = 16'h0; e.err = 1'b0; e.rd = '0;
    exp_q.push_back(e);
    REQ = 3'b010;
    for (int c = 0; c < 200 && SCL; c++) @(negedge Clk);
    check("bus_started", 32'(SCL), 32'd0);
    repeat (2) @(negedge Clk);
    #2 Reset = 1'b0;
    #1 check_outputs_zero("mid_reset");
    REQ = 3'b000;
    exp_q.delete();
    model_last = 2;
    model_rd   = '0;
    for (int c = 0; c < 400 && gen_busy; c++) @(negedge Clk);
    check("generator_quiet", 32'(gen_busy), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    txn_rnw[0][0] = 1'b0; txn_addr[0][0] = 7'h05; txn_wdata[0][0] = 16'hC0DE;
    txn_rnw[1][0] = 1'b1; txn_addr[1][0] = 7'h05; txn_wdata[1][0] = 16'h0000;
    run_round(1, 1, 0, 1'b0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      q0 = $urandom_range(0, 3);
      q1 = $urandom_range(0, 3);
      q2 = $urandom_range(0, 3);
      if (q0 + q1 + q2 == 0) q0 = 1;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 4; j++) begin
          txn_rnw[i][j]   = 1'($urandom);
          txn_addr[i][j]  = 7'($urandom_range(0, 7));
          txn_wdata[i][j] = 16'($urandom);
        end
      run_round(q0, q1, q2, ($urandom_range(0, 5) == 0), 1'($urandom));
    end

    repeat (5) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter IDLE_CYCLES, default 16, the number of consecutive SCL-high Clk cycles that marks transaction end.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, the number of Clk cycles allowed from START_STB until SCL first goes low.
REQ-003 SHALL have port Clk  in  1  system clock; one clock domain, all state on rising edge.
REQ-004 SHALL have port Reset  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port REQ  in  3  per-requester transaction request, level, held until own DONE.
REQ-006 SHALL have port REQ_RNW  in  3  per-requester read(1)/write(0).
REQ-007 SHALL have port REQ_ADDR  in  21  packed 3x7-bit target addresses, requester i at bits [7i+6:7i].
REQ-008 SHALL have port REQ_WDATA  in  48  packed 3x16-bit write data, requester i at bits [16i+15:16i].
REQ-009 SHALL have port GNT  out  3  one-hot grant, high from grant through FINISH.
REQ-010 SHALL have port DONE  out  3  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port ERR  out  1  one-cycle pulse with DONE when start timeout occurred.
REQ-012 SHALL have port RD_DATA_OUT  out  16  last read result.
REQ-013 SHALL have ports START_STB out 1, RNW out 1, I2C_ADDR out 7, WR_DATA out 16, driving the I2C generator's CPU interface.
REQ-014 SHALL have ports SCL in 1 and RD_DATA in 16, sourced from the generator.

Function
REQ-015 SHALL implement states IDLE, LAUNCH, WAIT_START, BUSY, FINISH.
REQ-016 IDLE: with any REQ bit high, SHALL grant round-robin, searching from index (last_grant+1) mod 3 upward; latch that requester's RNW/ADDR/WDATA onto RNW/I2C_ADDR/WR_DATA, set GNT, go LAUNCH next cycle.
REQ-017 LAUNCH: SHALL assert START_STB for exactly one Clk cycle, then go WAIT_START.
REQ-018 WAIT_START: SHALL count Clk cycles; SCL low goes BUSY, counter cleared; counter reaching TIMEOUT_CYCLES with SCL still high goes FINISH with error flag set.
REQ-019 BUSY: SHALL increment idle counter while SCL high, clear it when SCL low; counter equal to IDLE_CYCLES goes FINISH.
REQ-020 FINISH: SHALL pulse DONE[g] one cycle, pulse ERR if error flag set, load RD_DATA_OUT from RD_DATA only if RNW=1 and no error, update last_grant=g, clear GNT and error flag, go IDLE.
REQ-021 RNW, I2C_ADDR, WR_DATA SHALL stay constant from LAUNCH through FINISH; REQ/REQ_* changes during a transaction SHALL be ignored.
REQ-022 A requester dropping REQ mid-transaction SHALL NOT abort it; DONE is still pulsed.
REQ-023 Arbitration SHALL occur only in IDLE; simultaneous requests resolved solely by REQ-016; minimum grant-to-grant spacing 1 IDLE cycle.
REQ-024 Counters SHALL be wide enough for max(IDLE_CYCLES, TIMEOUT_CYCLES) and SHALL saturate, never wrap.
REQ-025 DONE and ERR SHALL never be high outside FINISH; at most one GNT/DONE bit high.

Reset
REQ-026 Reset low SHALL immediately force state IDLE, GNT=0, DONE=0, ERR=0, START_STB=0, RNW=0, I2C_ADDR=0, WR_DATA=0, RD_DATA_OUT=0, counters=0, last_grant=2.
REQ-027 Reset mid-transaction SHALL abandon it without DONE; first grant after release follows REQ-016 with last_grant=2.

Structure
REQ-028 Shared package i2c_pkg SHALL hold state encoding, address width 7, data width 16, requester count 3, IDLE_CYCLES/TIMEOUT_CYCLES defaults.
REQ-029 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs REQ, last_grant; output one-hot grant).

Verification
REQ-030 REQ=3'b001, REQ_RNW[0]=0, addr 7'h2A, data 16'hBEEF, generator + receptor (addr 7'h2A) connected -> one START_STB, I2C_ADDR=7'h2A, WR_DATA=16'hBEEF, DONE=3'b001 once, receptor stores 16'hBEEF.
REQ-031 REQ=3'b111 held continuously -> grant order 0,1,2,0; each DONE precedes next GNT.
REQ-032 Requester 1 read from receptor holding 16'h1234 -> RD_DATA_OUT=16'h1234 in FINISH+1, ERR=0.
REQ-033 SCL tied high, REQ=3'b100 -> DONE=3'b100 and ERR=1 same cycle, 64+ cycles after START_STB; RD_DATA_OUT unchanged.
REQ-034 Reset asserted in BUSY -> all outputs 0 same cycle, no DONE; after release REQ=3'b011 grants requester 0 first.
